// File: rtl/tick_monitor_pkg.sv
// Shared types and constants for the tick strobe monitor.
package tick_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } tick_mon_state_e;

    localparam int ERR_WIDTH = 8;

endpackage

// File: rtl/tick_monitor.sv
// Receive-side checker for a periodic one-cycle strobe: measures tick-to-tick
// interval, flags early/late strobes and reports lock once the period is stable.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int EXPECTED_PERIOD = 6,
    parameter int TOLERANCE       = 0,
    parameter int CNT_WIDTH       = 5,
    parameter int LOCK_COUNT      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 period_valid_o,
    output logic                 early_o,
    output logic                 late_o,
    output logic [ERR_WIDTH-1:0] err_count_o
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH:0]   EARLY_LIM = (CNT_WIDTH+1)'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] LATE_CNT  = CNT_WIDTH'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [GOOD_W-1:0]    LOCK_LAST = GOOD_W'(LOCK_COUNT - 1);

    tick_mon_state_e      state, state_n;
    logic [CNT_WIDTH-1:0] cnt;
    logic [GOOD_W-1:0]    good_cnt, good_n;
    logic                 late_seen;

    logic                 active, meas, late_now, early_now, good_now, err_ev;
    logic [CNT_WIDTH:0]   interval;
    logic [CNT_WIDTH-1:0] period_sat;

    assign interval   = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign period_sat = (&cnt) ? cnt : interval[CNT_WIDTH-1:0];

    always_comb begin
        active    = (state != IDLE);
        meas      = active && tick_i;
        // late is armed only once per interval; the tick that ends a late
        // interval is reported but earns no credit
        late_now  = active && (cnt == LATE_CNT) && !late_seen;
        early_now = meas && (interval < EARLY_LIM);
        good_now  = meas && !early_now && !late_seen && !late_now;
        err_ev    = early_now || late_now;

        state_n = state;
        good_n  = good_cnt;
        case (state)
            IDLE: begin
                if (tick_i) state_n = ACQUIRE;
            end
            ACQUIRE: begin
                if (err_ev) begin
                    good_n = '0;
                end else if (good_now) begin
                    if (good_cnt == LOCK_LAST) begin
                        state_n = LOCKED;
                        good_n  = '0;
                    end else begin
                        good_n = good_cnt + GOOD_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (err_ev) begin
                    state_n = ACQUIRE;
                    good_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                good_n  = '0;
            end
        endcase

        if (clear_i) begin
            state_n = IDLE;
            good_n  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_n;
            good_cnt <= good_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            late_seen      <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            early_o        <= 1'b0;
            late_o         <= 1'b0;
            err_count_o    <= '0;
            locked_o       <= 1'b0;
        end else if (clear_i) begin
            cnt            <= '0;
            late_seen      <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            early_o        <= 1'b0;
            late_o         <= 1'b0;
            err_count_o    <= '0;
            locked_o       <= 1'b0;
        end else begin
            if (tick_i)      cnt <= '0;
            else if (!(&cnt)) cnt <= cnt + CNT_WIDTH'(1);

            if (tick_i)        late_seen <= 1'b0;
            else if (late_now) late_seen <= 1'b1;

            period_valid_o <= meas;
            if (meas) period_o <= period_sat;
            early_o <= early_now;
            late_o  <= late_now;
            if (err_ev && !(&err_count_o)) err_count_o <= err_count_o + ERR_WIDTH'(1);
            locked_o <= (state_n == LOCKED);
        end
    end

endmodule

// File: tb/tb_tick_monitor.sv
// Randomized self-checking bench for tick_monitor against an elapsed-time
// reference model of the strobe rules (default parameters).
module tb_tick_monitor;

    localparam int EP = 6;
    localparam int TOL = 0;
    localparam int LC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       locked_o, period_valid_o, early_o, late_o;
    logic [4:0] period_o;
    logic [7:0] err_count_o;

    tick_monitor #(.EXPECTED_PERIOD(EP), .TOLERANCE(TOL), .CNT_WIDTH(5), .LOCK_COUNT(LC)) dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .clear_i(clear_i),
        .locked_o(locked_o), .period_o(period_o), .period_valid_o(period_valid_o),
        .early_o(early_o), .late_o(late_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {locked_o, period_o, period_valid_o, early_o, late_o, err_count_o};

    int checks = 0;
    int errors = 0;

    // reference model: mode 0 idle, 1 acquiring, 2 locked; elapsed = interval
    // a tick would report if it arrived in the current cycle
    int m_mode, m_elapsed, m_streak, m_err, m_period;
    bit m_late_flag, m_pv, m_early, m_late;
    logic [16:0] expv;

    task automatic model_reset();
        m_mode = 0; m_elapsed = 1; m_streak = 0; m_err = 0; m_period = 0;
        m_late_flag = 0; m_pv = 0; m_early = 0; m_late = 0;
        expv = '0;
    endtask

    task automatic model_step(input bit t, input bit c);
        bit active, good;
        if (c) begin
            model_reset();
            return;
        end
        active = (m_mode != 0);
        m_pv = 0; m_early = 0; m_late = 0; good = 0;
        if (active && m_elapsed == EP + TOL + 1 && !m_late_flag) begin
            m_late = 1;
            m_late_flag = 1;
        end
        if (t && active) begin
            m_pv = 1;
            m_period = (m_elapsed > 31) ? 31 : m_elapsed;
            m_early = (m_elapsed < EP - TOL);
            good = !m_early && !m_late_flag;
        end
        if (m_early || m_late) begin
            if (m_err < 255) m_err++;
            if (m_mode == 2) m_mode = 1;
            m_streak = 0;
        end else if (good && m_mode == 1) begin
            m_streak++;
            if (m_streak == LC) begin
                m_mode = 2;
                m_streak = 0;
            end
        end
        if (t && !active) m_mode = 1;
        if (t) begin
            m_elapsed = 1;
            m_late_flag = 0;
        end else begin
            m_elapsed++;
        end
        expv = {(m_mode == 2), 5'(m_period), m_pv, m_early, m_late, 8'(m_err)};
    endtask

    // one clock: inputs change at negedge, outputs are then sampled at the next negedge
    task automatic drive(input bit t, input bit c);
        tick_i = t;
        clear_i = c;
        model_step(t, c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", obs, 17'd0);
        end
        rst = 1'b0;
        drive(0, 0);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", obs, expv);
        end
    endtask

    task automatic test_nominal();
        int gaps[8] = '{3, 6, 6, 6, 6, 6, 6, 6};
        foreach (gaps[g]) begin
            for (int j = 1; j <= gaps[g]; j++) begin
                drive(j == gaps[g], 0);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL nominal gap %0d cyc %0d got %h exp %h", g, j, obs, expv);
                end
            end
        end
        checks++;
        if (locked_o !== 1'b1 || err_count_o !== 8'd0) begin
            errors++;
            $display("FAIL nominal_lock got locked %b err %0d exp locked 1 err 0", locked_o, err_count_o);
        end
    endtask

    task automatic test_early();
        int gaps[5] = '{4, 6, 6, 6, 6};
        foreach (gaps[g]) begin
            for (int j = 1; j <= gaps[g]; j++) begin
                drive(j == gaps[g], 0);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL early gap %0d cyc %0d got %h exp %h", g, j, obs, expv);
                end
            end
            if (g == 0) begin
                checks++;
                if (early_o !== 1'b1 || period_o !== 5'd4 || locked_o !== 1'b0 || err_count_o !== 8'd1) begin
                    errors++;
                    $display("FAIL early_event got e%b p%0d l%b err%0d exp e1 p4 l0 err1",
                             early_o, period_o, locked_o, err_count_o);
                end
            end
        end
    endtask

    task automatic test_late();
        drive(0, 1);
        begin
            int gaps[7] = '{2, 6, 6, 6, 9, 6, 6};
            foreach (gaps[g]) begin
                for (int j = 1; j <= gaps[g]; j++) begin
                    drive(j == gaps[g], 0);
                    checks++;
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL late gap %0d cyc %0d got %h exp %h", g, j, obs, expv);
                    end
                    if (g == 4 && j == 7) begin
                        checks++;
                        if (late_o !== 1'b1 || locked_o !== 1'b0) begin
                            errors++;
                            $display("FAIL late_event got late %b locked %b exp late 1 locked 0", late_o, locked_o);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_clear();
        drive(1, 1);
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL clear_with_tick got %h exp %h", obs, 17'd0);
        end
        for (int j = 1; j <= 6; j++) begin
            drive(j == 3 || j == 6, 0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL clear_after cyc %0d got %h exp %h", j, obs, expv);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int g = 0; g < 3; g++) begin
            for (int j = 1; j <= 6; j++) begin
                drive(j == 6, 0);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL pre_reset gap %0d cyc %0d got %h exp %h", g, j, obs, expv);
                end
            end
        end
        drive(0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", obs, 17'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = (n % 3 == 0) ? int'($urandom_range(10, 1)) : int'($urandom_range(EP + TOL, EP - TOL));
            for (int j = 1; j <= gap; j++) begin
                drive(j == gap, $urandom_range(39, 0) == 0);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL random iter %0d cyc %0d got %h exp %h", n, j, obs, expv);
                end
            end
        end
    endtask

    task automatic test_saturate();
        drive(0, 1);
        drive(1, 0);
        for (int j = 0; j < 300; j++) begin
            drive(1, 0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL saturate cyc %0d got %h exp %h", j, obs, expv);
            end
        end
        checks++;
        if (err_count_o !== 8'd255 || early_o !== 1'b1) begin
            errors++;
            $display("FAIL saturate_end got err %0d early %b exp err 255 early 1", err_count_o, early_o);
        end
        drive(0, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_early();
        test_late();
        test_clear();
        test_async_reset();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_monitor.md
# tick_monitor

Receive-side checker for the periodic one-cycle strobe produced by the team's pulse-generating counter. It measures the clock-cycle interval between strobes, flags early and late strobes, and reports lock once the strobe is stable. It sits on the consumer side of every tick line, so downstream logic can trust `locked_o` before acting on ticks.

## Interface
- `EXPECTED_PERIOD`, default 6: nominal cycles between tick rising samples.
- `TOLERANCE`, default 0: allowed ± deviation in cycles; must satisfy `TOLERANCE < EXPECTED_PERIOD - 1`.
- `CNT_WIDTH`, default 5: interval counter width; must hold `EXPECTED_PERIOD + TOLERANCE + 1`.
- `LOCK_COUNT`, default 3: consecutive good intervals required to lock.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_i`  in  1  strobe under test, synchronous to `clk`.
- `clear_i`  in  1  synchronous soft clear.
- `locked_o`  out  1  stable-period indication.
- `period_o`  out  CNT_WIDTH  last measured interval, saturating at 2^CNT_WIDTH-1.
- `period_valid_o`  out  1  one-cycle pulse when `period_o` updates.
- `early_o`  out  1  one-cycle pulse when an early tick occurs.
- `late_o`  out  1  one-cycle pulse when a late timeout occurs.
- `err_count_o`  out  8  count of early plus late events, saturating at 255.

## Operation
- `cnt` is cleared to 0 in any cycle with `tick_i`=1. Otherwise it increments, saturating at all-ones. The measured interval is `cnt+1`.
- The states are IDLE, ACQUIRE and LOCKED. Reset and `clear_i` both enter IDLE.
- IDLE transitions:
  - A tick moves to ACQUIRE.
  - No measurement is made, `period_valid_o` stays 0, and no late check runs.
- Every tick in ACQUIRE or LOCKED is classified as follows:
  - `period_valid_o` fires and `period_o` = `cnt+1`.
  - Early: `cnt+1 < EXPECTED_PERIOD-TOLERANCE`.
  - Good: the interval is inside the window and no late event occurred in this interval.
- Late timeout rules:
  - Late fires in ACQUIRE/LOCKED in the cycle where `cnt == EXPECTED_PERIOD+TOLERANCE`, whether or not `tick_i` is high.
  - It fires exactly once per interval, and sets `late_seen`.
  - The next tick clears `late_seen`, reports its period, and is neither good nor early.
- ACQUIRE transitions:
  - A good tick increments `good_cnt`. When `good_cnt` reaches `LOCK_COUNT`, the state moves to LOCKED.
  - An early or late event clears `good_cnt`.
- LOCKED transitions: an early or late event moves to ACQUIRE and clears `good_cnt`. Good ticks hold the state in LOCKED.
- `err_count_o` increments by 1 per early or late event.
  - Early and late cannot both fire in one cycle, because they require disjoint `cnt` values.
  - The count saturates at 255, with no wrap.
- `clear_i` rules:
  - It returns the block to IDLE and clears `cnt`, `good_cnt`, `late_seen`, `err_count_o`, `period_o` and `locked_o`.
  - It overrides a simultaneous tick: that tick is neither measured nor allowed to leave IDLE.

## Timing
- All outputs are registered.
- `period_valid_o`, `early_o` and `late_o` assert in the cycle after the causing tick or timeout.
- `locked_o` follows the state: it rises the cycle after the LOCK_COUNT-th good tick and falls the cycle after the early or late event.
- Reset values: every output is 0, state is IDLE, and all internal counters are 0.
- Reset has effect immediately and asynchronously, including mid-lock. Operation resumes on the first edge after `rst` deasserts.
- If `tick_i` is high for consecutive cycles, each cycle is a tick with interval 1.

## Structure
- Package `tick_monitor_pkg` holds:
  - the state enum typedef `tick_mon_state_e` (IDLE, ACQUIRE, LOCKED);
  - `ERR_WIDTH` = 8.
- Single module, no sub-module. The state register, interval counter, `good_cnt` and saturating error counter are all local.

## Test plan
- Defaults, tick every 6 cycles from reset:
  - `period_valid_o` fires on every tick except the first, with `period_o`=6.
  - `locked_o` rises one cycle after the 4th tick.
  - `err_count_o` stays 0.
- Locked, then one tick at interval 4:
  - `early_o` pulses once and `period_o`=4.
  - `locked_o` falls and `err_count_o`=1.
  - Relock occurs after 3 more good intervals.
- Locked, then tick withheld until interval 9:
  - `late_o` pulses one cycle after `cnt`=6, with `locked_o` falling the same cycle.
  - At the tick, `period_o`=9, with no `early_o` and no good credit.
  - `err_count_o`=1.
- Locked, `clear_i` and `tick_i` high in the same cycle:
  - Next cycle: IDLE, all outputs 0, and no `period_valid_o`.
  - The following tick only leaves IDLE.
- `rst` asserted mid-interval while locked: all outputs drop to 0 without waiting for a clock edge.
- `tick_i` held high for 300 cycles after the first tick:
  - `early_o` pulses every cycle.
  - `err_count_o` saturates at 255 and stays there.
